// File: rtl/reset_pulse_gen.sv
// Reset pulse source for a downstream active-low reset domain: a power-on pulse
// after block reset, then software-requested pulses, each followed by a settle window and done.
module reset_pulse_gen #(
    parameter int CNT_W         = 8,
    parameter int PULSE_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int EVT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [CNT_W-1:0] pulse_len,
    output logic             rst_out_n,
    output logic             busy,
    output logic             done,
    output logic [EVT_W-1:0] evt_cnt
);

    typedef enum logic [1:0] {POR, IDLE, ASSERT, SETTLE} state_t;

    localparam logic [CNT_W-1:0] PULSE_DEF   = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [EVT_W-1:0] EVT_ONE     = EVT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] len, len_nxt;
    logic             rst_out_n_nxt, busy_nxt, done_nxt;
    logic [EVT_W-1:0] evt_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= POR;
            cnt       <= '0;
            len       <= PULSE_DEF;
            rst_out_n <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            evt_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            len       <= len_nxt;
            rst_out_n <= rst_out_n_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            evt_cnt   <= evt_cnt_nxt;
        end
    end

    // Outputs are computed here as next-state values so every output leaves a flop.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt + CNT_ONE;
        len_nxt       = len;
        rst_out_n_nxt = rst_out_n;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        evt_cnt_nxt   = evt_cnt;

        case (state)
            POR: begin
                rst_out_n_nxt = 1'b0;
                busy_nxt      = 1'b1;
                if (cnt == PULSE_LAST) begin
                    state_nxt     = SETTLE;
                    rst_out_n_nxt = 1'b1;
                    cnt_nxt       = '0;
                end
            end
            IDLE: begin
                cnt_nxt       = cnt;
                rst_out_n_nxt = 1'b1;
                busy_nxt      = 1'b0;
                if (req) begin
                    state_nxt     = ASSERT;
                    rst_out_n_nxt = 1'b0;
                    busy_nxt      = 1'b1;
                    cnt_nxt       = '0;
                    len_nxt       = (pulse_len == '0) ? PULSE_DEF : pulse_len;
                    if (evt_cnt != '1)
                        evt_cnt_nxt = evt_cnt + EVT_ONE;
                end
            end
            ASSERT: begin
                rst_out_n_nxt = 1'b0;
                busy_nxt      = 1'b1;
                if (cnt == len - CNT_ONE) begin
                    state_nxt     = SETTLE;
                    rst_out_n_nxt = 1'b1;
                    cnt_nxt       = '0;
                end
            end
            SETTLE: begin
                rst_out_n_nxt = 1'b1;
                busy_nxt      = 1'b1;
                if (cnt == SETTLE_LAST) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt     = POR;
                cnt_nxt       = '0;
                rst_out_n_nxt = 1'b0;
                busy_nxt      = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_reset_pulse_gen.sv
// Randomized bench for reset_pulse_gen: an edge-time model (sequence start + length)
// checked every cycle, plus literal timing checks for POR, short/default pulses, back-to-back and saturation.
module tb_reset_pulse_gen;
    localparam int CNT_W = 8, PULSE = 16, SETTLE = 4, EVT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req = 1'b0;
    logic [CNT_W-1:0] pulse_len = '0;
    logic             rst_out_n, busy, done;
    logic [EVT_W-1:0] evt_cnt;
    logic             s_rst_out_n, s_busy, s_done;
    logic [1:0]       s_evt_cnt;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    reset_pulse_gen #(.CNT_W(CNT_W), .PULSE_CYCLES(PULSE), .SETTLE_CYCLES(SETTLE), .EVT_W(EVT_W)) u_dut (
        .clk(clk), .rst(rst), .req(req), .pulse_len(pulse_len),
        .rst_out_n(rst_out_n), .busy(busy), .done(done), .evt_cnt(evt_cnt));

    reset_pulse_gen #(.CNT_W(CNT_W), .PULSE_CYCLES(PULSE), .SETTLE_CYCLES(SETTLE), .EVT_W(2)) u_sat (
        .clk(clk), .rst(rst), .req(req), .pulse_len(pulse_len),
        .rst_out_n(s_rst_out_n), .busy(s_busy), .done(s_done), .evt_cnt(s_evt_cnt));

    // Model: edge n counts non-reset rising edges. A sequence is (start edge s, length L):
    // rst_out_n low while n < s+L, busy while n < s+L+SETTLE, done when n == s+L+SETTLE.
    // POR behaves like a sequence started at the last edge seen while in reset.
    longint n = 0, s = 0, L = PULSE;
    int     evt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s = n; L = PULSE; evt = 0;
        end else begin
            n = n + 1;
            if (n > s + L + SETTLE && req) begin
                s = n;
                L = (pulse_len == 0) ? PULSE : pulse_len;
                evt = evt + 1;
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("rst_out_n", rst_out_n, (n >= s + L) ? 1 : 0);
        chk("busy", busy, (n < s + L + SETTLE) ? 1 : 0);
        chk("done", done, (n == s + L + SETTLE) ? 1 : 0);
        chk("evt_cnt", evt_cnt, (evt > 255) ? 255 : evt);
        chk("sat_evt_cnt", s_evt_cnt, (evt > 3) ? 3 : evt);
        chk("sat_rst_out_n", s_rst_out_n, rst_out_n);
        chk("sat_done", s_done, done);
        chk("sat_busy", s_busy, busy);
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Called at the negedge where rst was just released (next posedge is edge 0).
    task automatic por_literal(input string tag);
        step(15);
        chk({tag, "_low_e14"}, rst_out_n, 0);
        chk({tag, "_busy"}, busy, 1);
        step(1);
        chk({tag, "_high_e15"}, rst_out_n, 1);
        step(3);
        chk({tag, "_nodone_e18"}, done, 0);
        step(1);
        chk({tag, "_done_e19"}, done, 1);
        chk({tag, "_evt"}, evt_cnt, 0);
        step(1);
        chk({tag, "_done_clr"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic accept(input int plen);
        req = 1'b1; pulse_len = CNT_W'(plen);
        step(1);
        req = 1'b0;
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        por_literal("por");

        // short programmed pulse, len 3
        accept(3);
        chk("p3_low_k", rst_out_n, 0);
        chk("p3_evt", evt_cnt, 1);
        step(2);
        chk("p3_low_k2", rst_out_n, 0);
        step(1);
        chk("p3_high_k3", rst_out_n, 1);
        step(4);
        chk("p3_done_k7", done, 1);

        // back-to-back: req coincident with done, pulse_len 0 -> default width, req held high
        req = 1'b1; pulse_len = '0;
        step(1);
        chk("b2b_low", rst_out_n, 0);
        chk("b2b_evt", evt_cnt, 2);
        step(15);
        chk("def_low_k15", rst_out_n, 0);
        step(1);
        chk("def_high_k16", rst_out_n, 1);
        step(4);
        chk("def_done_k20", done, 1);
        chk("held_evt", evt_cnt, 2);
        req = 1'b0;
        step(25);

        // mid-sequence reset during ASSERT of a len-10 pulse
        accept(10);
        step(1);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        chk("mid_rst_low", rst_out_n, 0);
        chk("mid_rst_evt", evt_cnt, 0);
        @(negedge clk);
        chk("mid_rst_low2", rst_out_n, 0);
        // edge 0 was the posedge just passed; resync by checking remaining POR edges
        step(14);
        chk("mid_por_low_e14", rst_out_n, 0);
        step(1);
        chk("mid_por_high_e15", rst_out_n, 1);
        step(4);
        chk("mid_por_done", done, 1);

        // saturation on the EVT_W=2 instance: 1,2,3,3,3
        for (int i = 0; i < 5; i++) begin
            accept(1);
            chk("sat_seq", s_evt_cnt, (i < 3) ? i + 1 : 3);
            step(6);
        end

        // randomized traffic, occasional async reset
        for (int c = 0; c < 3000; c++) begin
            req = ($urandom_range(0, 3) == 0);
            pulse_len = ($urandom_range(0, 4) == 0) ? '0 : CNT_W'($urandom_range(1, 24));
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
            step(1);
        end
        req = 1'b0;
        step(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
